hub75_top: RTL and testbench

// - Self-contained HUB75 LED-matrix scan driver with no pixel input port.
// - Pixels come from an internal deterministic test pattern.
// - Drives 4 RGB data lanes, a shift-register row selector (row_clk/row_data), shift clock, latch and blank.
// - Uses Binary Code Modulation (BCM) brightness and sits directly at the panel connector.

---
 rtl/hub75_pkg.sv | 23 ++
 rtl/hub75_pattern.sv | 38 +++
 rtl/hub75_top.sv | 165 ++++++++++++++++
 tb/tb_hub75_top.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_pkg : shared scan-state encoding and default geometry for hub75_top  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_ROW     = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_DISPLAY = 2'd3
  } hub75_state_t;

  localparam int ROW_CYCLES     = 3;
  localparam int COLS_DEF       = 64;
  localparam int SCAN_ROWS_DEF  = 32;
  localparam int BITS_DEF       = 8;
  localparam int DISP_BASE_DEF  = 8;
  localparam int LANES          = 4;

endpackage : hub75_pkg
`default_nettype wire

// File: rtl/hub75_pattern.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_pattern : test-pattern generator, (lane,row,col,plane) -> {r,g,b}    |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module hub75_pattern #(
  parameter int ROW_W   = 5,
  parameter int COL_W   = 6,
  parameter int PLANE_W = 3
) (
  input  logic [1:0]         i_lane,
  input  logic [ROW_W-1:0]   i_row,
  input  logic [COL_W-1:0]   i_col,
  input  logic [PLANE_W-1:0] i_plane,
  output logic               o_r,
  output logic               o_g,
  output logic               o_b
);

  logic [7:0] w_red;
  logic [7:0] w_grn;
  logic [7:0] w_blu;
  logic [2:0] w_bit_idx;
  logic       w_in_range;

  // Size casts zero-extend narrow indices and truncate wide ones to the field.
  assign w_red      = {6'(i_col), 2'b00};
  assign w_grn      = {5'(i_row), 3'b000};
  assign w_blu      = {i_lane, 6'b000000};
  assign w_bit_idx  = 3'(i_plane);
  assign w_in_range = (32'(i_plane) < 32'd8);

  assign o_r = w_in_range & w_red[w_bit_idx];
  assign o_g = w_in_range & w_grn[w_bit_idx];
  assign o_b = w_in_range & w_blu[w_bit_idx];

endmodule : hub75_pattern
`default_nettype wire

// File: rtl/hub75_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hub75_top : HUB75 scan driver with BCM brightness and built-in test pattern|
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module hub75_top
  import hub75_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int SCAN_ROWS = SCAN_ROWS_DEF,
  parameter int BITS      = BITS_DEF,
  parameter int DISP_BASE = DISP_BASE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic r1,
  output logic g1,
  output logic b1,
  output logic r2,
  output logic g2,
  output logic b2,
  output logic r3,
  output logic g3,
  output logic b3,
  output logic r4,
  output logic g4,
  output logic b4,
  output logic row_clk,
  output logic row_data,
  output logic clk_out,
  output logic lat,
  output logic blank
);

  localparam int K_W     = $clog2(2 * COLS);
  localparam int COL_W   = K_W - 1;
  localparam int ROW_W   = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1;
  localparam int PLANE_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DISP_W  = BITS + $clog2(DISP_BASE);

  // Counters describe the cycle the output registers will present next.
  hub75_state_t       r_state;
  logic [K_W-1:0]     r_k;
  logic [ROW_W-1:0]   r_row;
  logic [PLANE_W-1:0] r_plane;
  logic [DISP_W-1:0]  r_disp;

  logic [LANES-1:0]   r_red;
  logic [LANES-1:0]   r_grn;
  logic [LANES-1:0]   r_blu;
  logic               r_row_clk;
  logic               r_row_data;
  logic               r_clk_out;
  logic               r_lat;
  logic               r_blank;

  logic [LANES-1:0]   w_pat_r;
  logic [LANES-1:0]   w_pat_g;
  logic [LANES-1:0]   w_pat_b;
  logic [COL_W-1:0]   w_col;
  logic [DISP_W-1:0]  w_disp_last;

  assign w_col       = r_k[K_W-1:1];
  assign w_disp_last = DISP_W'((DISP_BASE << r_plane) - 1);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    hub75_pattern #(
      .ROW_W   (ROW_W),
      .COL_W   (COL_W),
      .PLANE_W (PLANE_W)
    ) u_pattern (
      .i_lane  (2'(gi)),
      .i_row   (r_row),
      .i_col   (w_col),
      .i_plane (r_plane),
      .o_r     (w_pat_r[gi]),
      .o_g     (w_pat_g[gi]),
      .o_b     (w_pat_b[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ROW;
      r_k        <= '0;
      r_row      <= '0;
      r_plane    <= '0;
      r_disp     <= '0;
      r_red      <= '0;
      r_grn      <= '0;
      r_blu      <= '0;
      r_row_clk  <= 1'b0;
      r_row_data <= 1'b0;
      r_clk_out  <= 1'b0;
      r_lat      <= 1'b0;
      r_blank    <= 1'b1;
    end else begin
      r_red      <= '0;
      r_grn      <= '0;
      r_blu      <= '0;
      r_row_clk  <= 1'b0;
      r_row_data <= 1'b0;
      r_clk_out  <= 1'b0;
      r_lat      <= 1'b0;
      r_blank    <= 1'b1;
      case (r_state)
        ST_ROW: begin
          // Data is held across the row_clk rise so the selector samples it cleanly.
          r_row_data <= (r_k < K_W'(2)) && (r_row == '0);
          r_row_clk  <= (r_k == K_W'(1));
          if (r_k == K_W'(ROW_CYCLES - 1)) begin
            r_k     <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_SHIFT: begin
          r_clk_out <= r_k[0];
          r_red     <= w_pat_r;
          r_grn     <= w_pat_g;
          r_blu     <= w_pat_b;
          if (r_k == K_W'(2 * COLS - 1)) begin
            r_k     <= '0;
            r_state <= ST_LATCH;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_LATCH: begin
          r_lat   <= 1'b1;
          r_disp  <= '0;
          r_state <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          r_blank <= 1'b0;
          if (r_disp == w_disp_last) begin
            if (r_plane == PLANE_W'(BITS - 1)) begin
              r_plane <= '0;
              r_row   <= (r_row == ROW_W'(SCAN_ROWS - 1)) ? '0 : r_row + ROW_W'(1);
              r_state <= ST_ROW;
            end else begin
              r_plane <= r_plane + PLANE_W'(1);
              r_state <= ST_SHIFT;
            end
          end else begin
            r_disp <= r_disp + DISP_W'(1);
          end
        end
        default: r_state <= ST_ROW;
      endcase
    end
  end

  assign {r1, r2, r3, r4} = {r_red[0], r_red[1], r_red[2], r_red[3]};
  assign {g1, g2, g3, g4} = {r_grn[0], r_grn[1], r_grn[2], r_grn[3]};
  assign {b1, b2, b3, b4} = {r_blu[0], r_blu[1], r_blu[2], r_blu[3]};
  assign row_clk  = r_row_clk;
  assign row_data = r_row_data;
  assign clk_out  = r_clk_out;
  assign lat      = r_lat;
  assign blank    = r_blank;

endmodule : hub75_top
`default_nettype wire

// File: tb/tb_hub75_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hub75_top : default-geometry and small-geometry HUB75 driver bench      |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_hub75_top;

  localparam logic [16:0] RST_VEC = 17'd1;
  localparam int M_ROWT  = 3075;
  localparam int S_FRAME = 864;

  logic clk;
  logic rst_m;
  logic rst_s;
  int   n_checks;
  int   n_errors;

  logic m_r1, m_g1, m_b1, m_r2, m_g2, m_b2, m_r3, m_g3, m_b3, m_r4, m_g4, m_b4;
  logic m_row_clk, m_row_data, m_clk_out, m_lat, m_blank;
  logic s_r1, s_g1, s_b1, s_r2, s_g2, s_b2, s_r3, s_g3, s_b3, s_r4, s_g4, s_b4;
  logic s_row_clk, s_row_data, s_clk_out, s_lat, s_blank;
  logic [16:0] vec_m;
  logic [16:0] vec_s;

  hub75_top u_dut (
    .clk(clk), .rst(rst_m),
    .r1(m_r1), .g1(m_g1), .b1(m_b1), .r2(m_r2), .g2(m_g2), .b2(m_b2),
    .r3(m_r3), .g3(m_g3), .b3(m_b3), .r4(m_r4), .g4(m_g4), .b4(m_b4),
    .row_clk(m_row_clk), .row_data(m_row_data), .clk_out(m_clk_out),
    .lat(m_lat), .blank(m_blank)
  );

  hub75_top #(.COLS(4), .SCAN_ROWS(32), .BITS(2), .DISP_BASE(2)) u_dut_small (
    .clk(clk), .rst(rst_s),
    .r1(s_r1), .g1(s_g1), .b1(s_b1), .r2(s_r2), .g2(s_g2), .b2(s_b2),
    .r3(s_r3), .g3(s_g3), .b3(s_b3), .r4(s_r4), .g4(s_g4), .b4(s_b4),
    .row_clk(s_row_clk), .row_data(s_row_data), .clk_out(s_clk_out),
    .lat(s_lat), .blank(s_blank)
  );

  assign vec_m = {m_r1, m_r2, m_r3, m_r4, m_g1, m_g2, m_g3, m_g4, m_b1, m_b2, m_b3, m_b4,
                  m_row_clk, m_row_data, m_clk_out, m_lat, m_blank};
  assign vec_s = {s_r1, s_r2, s_r3, s_r4, s_g1, s_g2, s_g3, s_g4, s_b1, s_b2, s_b3, s_b4,
                  s_row_clk, s_row_data, s_clk_out, s_lat, s_blank};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit pat_bit(input int val, input int p);
    return (p < 8) && (((val >> p) & 1) == 1);
  endfunction

  // Expected outputs t cycles after reset release, derived from the row timeline.
  function automatic logic [16:0] model(input int cols, input int rows, input int bits,
                                        input int db, input int t);
    int rt, ft, row, o, seg;
    logic [3:0] rr, gg, bb;
    logic rc, rd, co, lt, bl;
    rr = '0; gg = '0; bb = '0; rc = 0; rd = 0; co = 0; lt = 0; bl = 1;
    rt  = 3 + bits * (2 * cols + 1) + db * ((1 << bits) - 1);
    ft  = t % (rows * rt);
    row = ft / rt;
    o   = ft % rt;
    if (o < 3) begin
      rd = (o < 2) && (row == 0);
      rc = (o == 1);
    end else begin
      o = o - 3;
      for (int p = 0; p < bits; p++) begin
        seg = 2 * cols + 1 + (db << p);
        if (o >= 0 && o < seg) begin
          if (o < 2 * cols) begin
            co = (o % 2) == 1;
            for (int l = 0; l < 4; l++) begin
              rr[l] = pat_bit(((o / 2) % 64) * 4, p);
              gg[l] = pat_bit((row % 32) * 8, p);
              bb[l] = pat_bit(l * 64, p);
            end
          end else if (o == 2 * cols) begin
            lt = 1;
          end else begin
            bl = 0;
          end
        end
        o = o - seg;
      end
    end
    return {rr[0], rr[1], rr[2], rr[3], gg[0], gg[1], gg[2], gg[3],
            bb[0], bb[1], bb[2], bb[3], rc, rd, co, lt, bl};
  endfunction

  task automatic step_main(inout int t);
    logic r;
    r = rst_m;
    @(posedge clk);
    #1;
    if (r) begin
      t = -1;
      check("m_rst", 32'(vec_m), 32'(RST_VEC));
    end else begin
      t++;
      check($sformatf("m_t%0d", t), 32'(vec_m), 32'(model(64, 32, 8, 8, t)));
    end
  endtask

  task automatic step_small(inout int t);
    logic r;
    r = rst_s;
    @(posedge clk);
    #1;
    if (r) begin
      t = -1;
      check("s_rst", 32'(vec_s), 32'(RST_VEC));
    end else begin
      t++;
      check($sformatf("s_t%0d", t), 32'(vec_s), 32'(model(4, 32, 2, 2, t)));
    end
  endtask

  task automatic run_main();
    int t, target, rises, latw, run, n;
    bit lat_seen, lat_done, lat_before;
    logic p_co, p_lat, p_bl;
    int runs[$];
    bit latb[$];
    t = -1; rises = 0; latw = 0; run = 0;
    lat_seen = 0; lat_done = 0; lat_before = 0;
    p_co = 0; p_lat = 0; p_bl = 1;
    rst_m = 1'b1;
    repeat (4) step_main(t);
    rst_m  = 1'b0;
    target = 3 * M_ROWT + 3 + int'($urandom_range(0, 127));
    while (t < target) begin
      step_main(t);
      if (t <= M_ROWT) begin
        if (!lat_seen) begin
          if (m_clk_out && !p_co) rises++;
          if (m_lat) begin lat_seen = 1; latw = 1; end
        end else if (!lat_done) begin
          if (m_lat) latw++; else lat_done = 1;
        end
        if (!m_blank) begin
          if (p_bl) lat_before = p_lat;
          run++;
        end else if (run > 0) begin
          runs.push_back(run);
          latb.push_back(lat_before);
          run = 0;
        end
      end
      if (t == 0) check("first_row_data", 32'(m_row_data), 32'd1);
      if (t == 1) check("first_row_clk", 32'(m_row_clk), 32'd1);
      if (t == 14) begin
        check("c5_clk_out", 32'(m_clk_out), 32'd1);
        check("c5_r1", 32'(m_r1), 32'd0);
        check("c5_g1", 32'(m_g1), 32'd0);
        check("c5_b1", 32'(m_b1), 32'd0);
        check("c5_b3", 32'(m_b3), 32'd0);
      end
      if (t == 2003) begin
        check("p7_c40_r1", 32'(m_r1), 32'd1);
        check("p7_b1", 32'(m_b1), 32'd0);
        check("p7_b2", 32'(m_b2), 32'd0);
        check("p7_b3", 32'(m_b3), 32'd1);
        check("p7_b4", 32'(m_b4), 32'd1);
      end
      if (t == M_ROWT) begin
        check("row0_clk_rises", 32'(rises), 32'd64);
        check("row0_lat_width", 32'(latw), 32'd1);
        check("row0_bcm_runs", 32'(runs.size()), 32'd8);
        for (int i = 0; i < runs.size() && i < 8; i++) begin
          check($sformatf("bcm_len%0d", i), 32'(runs[i]), 32'(8 << i));
          check($sformatf("bcm_lat%0d", i), 32'(latb[i]), 32'd1);
        end
        check("row1_row_data", 32'(m_row_data), 32'd0);
      end
      if (t == M_ROWT + 1) check("row1_row_clk", 32'(m_row_clk), 32'd1);
      p_co = m_clk_out; p_lat = m_lat; p_bl = m_blank;
    end
    // Abort during the row-3 shift and confirm a clean restart.
    rst_m = 1'b1;
    step_main(t);
    check("midrst_blank", 32'(m_blank), 32'd1);
    n = int'($urandom_range(0, 2));
    repeat (n) step_main(t);
    rst_m = 1'b0;
    step_main(t);
    check("restart_row_data", 32'(m_row_data), 32'd1);
    repeat (M_ROWT + 100) step_main(t);
    for (int r = 0; r < 3; r++) begin
      rst_m = 1'b1;
      n = int'($urandom_range(1, 4));
      repeat (n) step_main(t);
      rst_m = 1'b0;
      n = int'($urandom_range(100, 4000));
      repeat (n) step_main(t);
    end
  endtask

  task automatic run_small();
    int t, rises;
    logic p_rc;
    t = -1; rises = 0; p_rc = 0;
    rst_s = 1'b1;
    repeat (4) step_small(t);
    rst_s = 1'b0;
    repeat (2 * S_FRAME + 40) begin
      step_small(t);
      if (t < S_FRAME && s_row_clk && !p_rc) rises++;
      if (t == S_FRAME) begin
        check("s_frame_row_clks", 32'(rises), 32'd32);
        check("s_frame2_row_data", 32'(s_row_data), 32'd1);
      end
      p_rc = s_row_clk;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_m    = 1'b1;
    rst_s    = 1'b1;
    fork
      run_main();
      run_small();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_hub75_top
`default_nettype wire
